// File: rtl/fp_alu_seq.sv
// fp_alu_seq: multi-cycle IEEE-754 add/sub/mul unit with valid/ready handshake,
// round-to-nearest-even, denormal flush-to-zero and per-result status flags.
module fp_alu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int XLEN = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      flags
);

    // Working mantissa: hidden one normally sits at bit NP, with one spare bit
    // above it for add carries / mul products in [2,4).
    localparam int WW = 2 * MAN_W + 2;
    localparam int NP = 2 * MAN_W;
    localparam int EW = EXP_W + 3;
    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO = '0;
    localparam logic [XLEN-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {IDLE, EXEC, NORM, RND, DONE} state_t;
    state_t state, state_nx;

    // Right-shift m by d; every bit shifted out is folded into the LSB as sticky.
    function automatic logic [WW-1:0] align_fn(input logic [WW-1:0] m, input logic [EXP_W-1:0] d);
        logic [WW-1:0] sh;
        logic [WW-1:0] lost;
        if (int'(d) >= WW) begin
            sh   = '0;
            lost = m;
        end else begin
            sh   = m >> d;
            lost = m & ~({WW{1'b1}} << d);
        end
        return {sh[WW-1:1], sh[0] | (|lost)};
    endfunction

    // Index of the most significant set bit (0 when m is zero).
    function automatic int lead_fn(input logic [WW-1:0] m);
        int pos;
        pos = 0;
        for (int i = 0; i < WW; i++) begin
            if (m[i]) pos = i;
        end
        return pos;
    endfunction

    // Round-to-nearest-even on a normalised mantissa.
    // Returns {inexact, rounded significand with carry bit}.
    function automatic logic [MAN_W+2:0] rne_fn(input logic [WW-1:0] m);
        logic             g, r, s, up;
        logic [MAN_W+1:0] sum;
        g   = m[MAN_W-1];
        r   = m[MAN_W-2];
        s   = |m[MAN_W-3:0];
        up  = g & (r | s | m[MAN_W]);
        sum = m[WW-1:MAN_W] + {{(MAN_W+1){1'b0}}, up};
        return {g | r | s, sum};
    endfunction

    // Apply the rounding carry, then saturate to inf or flush to zero.
    // Returns {flags, packed result}.
    function automatic logic [XLEN+3:0] pack_fn(input logic sgn, input logic signed [EW-1:0] e,
                                                input logic [MAN_W+2:0] rnd);
        logic signed [EW-1:0] er;
        logic                 nz;
        er = e + EW'(rnd[MAN_W+1]);
        nz = rnd[MAN_W+1] | rnd[MAN_W];
        if (!nz)
            return {4'b0000, {XLEN{1'b0}}};
        else if (er >= EMAX)
            return {4'b0101, sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (er <= EZERO)
            return {4'b0011, sgn, {(XLEN-1){1'b0}}};
        else
            return {3'b000, rnd[MAN_W+2], sgn, er[EXP_W-1:0], rnd[MAN_W-1:0]};
    endfunction

    logic [1:0]      op_p0;
    logic [XLEN-1:0] a_p0, b_p0;

    logic                 byp_p1;
    logic [XLEN-1:0]      byp_res_p1;
    logic [3:0]           byp_flg_p1;
    logic                 sign_p1;
    logic signed [EW-1:0] exp_p1;
    logic [WW-1:0]        mant_p1;

    logic signed [EW-1:0] exp_p2;
    logic [WW-1:0]        mant_p2;

    logic                 sa, sb, sbe;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, snan;

    assign {sa, ea, fa} = a_p0;
    assign {sb, eb, fb} = b_p0;
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);
    assign snan   = (a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1]);
    assign sbe    = sb ^ (op_p0 == OP_SUB);

    logic                 a_big, s_l;
    logic [EXP_W-1:0]     e_l, e_s;
    logic [MAN_W-1:0]     f_l, f_s;
    logic [WW-1:0]        m_l, m_s, m_al, m_add, m_mul;
    logic signed [EW-1:0] e_mul;

    assign m_mul = WW'({1'b1, fa}) * WW'({1'b1, fb});
    assign e_mul = $signed({3'b000, ea}) + $signed({3'b000, eb}) - BIAS;

    // Add/sub datapath: order by magnitude, align the smaller operand, add or subtract.
    always_comb begin
        a_big = (ea > eb) || ((ea == eb) && (fa >= fb));
        e_l   = a_big ? ea : eb;
        e_s   = a_big ? eb : ea;
        f_l   = a_big ? fa : fb;
        f_s   = a_big ? fb : fa;
        s_l   = a_big ? sa : sbe;
        m_l   = {1'b0, 1'b1, f_l, {MAN_W{1'b0}}};
        m_s   = {1'b0, 1'b1, f_s, {MAN_W{1'b0}}};
        m_al  = align_fn(m_s, e_l - e_s);
        m_add = (sa ^ sbe) ? (m_l - m_al) : (m_l + m_al);
    end

    logic                 byp_x, sign_x;
    logic [XLEN-1:0]      byp_res_x;
    logic [3:0]           byp_flg_x;
    logic signed [EW-1:0] exp_x;
    logic [WW-1:0]        mant_x;

    // Special-operand resolution and choice of the arithmetic path.
    always_comb begin
        byp_x     = 1'b1;
        byp_res_x = QNAN;
        byp_flg_x = 4'b1000;
        sign_x    = s_l;
        exp_x     = $signed({3'b000, e_l});
        mant_x    = m_add;
        if (op_p0 == OP_RSV) begin
            byp_flg_x = 4'b1000;
        end else if (a_nan | b_nan) begin
            byp_flg_x = {snan, 3'b000};
        end else if (op_p0 == OP_MUL) begin
            sign_x = sa ^ sb;
            exp_x  = e_mul;
            mant_x = m_mul;
            if ((a_inf & b_zero) | (b_inf & a_zero)) begin
                byp_flg_x = 4'b1000;
            end else if (a_inf | b_inf) begin
                byp_res_x = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                byp_flg_x = 4'b0000;
            end else if (a_zero | b_zero) begin
                byp_res_x = {sa ^ sb, {(XLEN-1){1'b0}}};
                byp_flg_x = 4'b0000;
            end else begin
                byp_x = 1'b0;
            end
        end else begin
            if (a_inf & b_inf & (sa != sbe)) begin
                byp_flg_x = 4'b1000;
            end else if (a_inf) begin
                byp_res_x = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                byp_flg_x = 4'b0000;
            end else if (b_inf) begin
                byp_res_x = {sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                byp_flg_x = 4'b0000;
            end else if (a_zero & b_zero) begin
                byp_res_x = {sa & sbe, {(XLEN-1){1'b0}}};
                byp_flg_x = 4'b0000;
            end else if (a_zero) begin
                byp_res_x = {sbe, eb, fb};
                byp_flg_x = 4'b0000;
            end else if (b_zero) begin
                byp_res_x = {sa, ea, fa};
                byp_flg_x = 4'b0000;
            end else begin
                byp_x = 1'b0;
            end
        end
    end

    logic [WW-1:0]        mant_n;
    logic signed [EW-1:0] exp_n;
    int                   lz;

    // Normalise: one-bit right shift on carry, leading-one left shift on cancellation.
    always_comb begin
        lz     = NP - lead_fn(mant_p1);
        mant_n = mant_p1;
        exp_n  = exp_p1;
        if (mant_p1[WW-1]) begin
            mant_n = {1'b0, mant_p1[WW-1:2], mant_p1[1] | mant_p1[0]};
            exp_n  = exp_p1 + EW'(1);
        end else if (|mant_p1) begin
            mant_n = mant_p1 << lz;
            exp_n  = exp_p1 - EW'(lz);
        end
    end

    logic [MAN_W+2:0] rnd_x;
    logic [XLEN+3:0]  fin_x;

    assign rnd_x = rne_fn(mant_p2);
    assign fin_x = pack_fn(sign_p1, exp_p2, rnd_x);

    // Datapath registers: operand latch, EXEC results, NORM results.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            op_p0 <= op;
            a_p0  <= in1;
            b_p0  <= in2;
        end
        if (state == EXEC) begin
            byp_p1     <= byp_x;
            byp_res_p1 <= byp_res_x;
            byp_flg_p1 <= byp_flg_x;
            sign_p1    <= sign_x;
            exp_p1     <= exp_x;
            mant_p1    <= mant_x;
        end
        if (state == NORM) begin
            exp_p2  <= exp_n;
            mant_p2 <= mant_n;
        end
    end

    // State register and result/flags capture at the end of rounding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            flags  <= '0;
        end else begin
            state <= state_nx;
            if (state == RND) begin
                if (byp_p1) {flags, result} <= {byp_flg_p1, byp_res_p1};
                else        {flags, result} <= fin_x;
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = EXEC;
            end
            EXEC: state_nx = NORM;
            NORM: state_nx = RND;
            RND:  state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_alu_seq.sv
// tb_fp_alu_seq: directed vectors for fp_alu_seq in binary32 configuration.
module tb_fp_alu_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op;
    logic [31:0] in1, in2, result;
    logic [3:0]  flags;
    logic        saw;
    int          n_chk = 0;
    int          n_err = 0;

    fp_alu_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, check latency/result/flags; drain to IDLE if out_ready is high.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'd3);
        chk({tag, ".res"}, result, er);
        chk({tag, ".flg"}, 32'(flags), 32'(ef));
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 2'b00; in1 = '0; in2 = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result",    result,         32'h0);
        chk("rst.flags",     32'(flags),     32'h0);
        rst = 1'b0;

        // handshake with back-pressure
        run_op("add1.5", 2'b00, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 4'b0000);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold.res", result,         32'h40400000);
            chk("hold.rdy", 32'(in_ready),  32'd0);
            chk("hold.vld", 32'(out_valid), 32'd1);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release.rdy", 32'(in_ready),  32'd1);
        chk("release.vld", 32'(out_valid), 32'd0);

        // sub and mul
        run_op("sub1-1",  2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000);
        run_op("sub2-1",  2'b01, 32'h40000000, 32'h3F800000, 32'h3F800000, 4'b0000);
        run_op("mul10x-20", 2'b10, 32'h41200000, 32'hC1A00000, 32'hC3480000, 4'b0000);
        run_op("mul-1x-1",  2'b10, 32'hBF800000, 32'hBF800000, 32'h3F800000, 4'b0000);

        // rounding
        run_op("rne.tie",  2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001);
        run_op("rne.odd",  2'b00, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001);

        // range
        run_op("ovf", 2'b10, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
        run_op("unf", 2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);

        // specials
        run_op("inf*0",   2'b10, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        run_op("inf-inf", 2'b00, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000);
        run_op("qnan",    2'b10, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
        run_op("snan",    2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_op("op11",    2'b11, 32'h3F800000, 32'h40000000, 32'h7FC00000, 4'b1000);
        run_op("-inf+1",  2'b00, 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000);
        run_op("-0*1",    2'b10, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);

        // reset asserted while the op is in NORM
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; in1 = 32'h3FC00000; in2 = 32'h3FC00000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        saw = out_valid;
        @(posedge clk);
        #1 rst = 1'b0;
        saw = saw | out_valid;
        chk("rmid.rdy", 32'(in_ready), 32'd1);
        repeat (6) begin
            @(posedge clk);
            #1 saw = saw | out_valid;
        end
        chk("rmid.novld", 32'(saw), 32'd0);
        run_op("rmid.next", 2'b10, 32'h41200000, 32'hC1A00000, 32'hC3480000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
